// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling datapath.
// Also used by the key selector that the PRGA block reuses.
package rc4_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        WAIT_I,
        CALC_J,
        WAIT_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // A key length of zero, or one above the maximum, means "use every key byte".
    function automatic int eff_key_len(input int key_len, input int max_len);
        if (key_len == 0 || key_len > max_len) begin
            return max_len;
        end
        return key_len;
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Control handshake plus the single-port S-array RAM bus for the KSA engine.
// The engine uses the master modport; the RAM mux and controller use the slave modport.
interface rc4_ksa_engine_if #(
    parameter int ADDR_W        = 8,
    parameter int MAX_KEY_BYTES = 3
);
    import rc4_pkg::*;

    logic                                  start;
    logic [MAX_KEY_BYTES*8-1:0]            key;
    logic [$clog2(MAX_KEY_BYTES+1)-1:0]    key_len;
    logic                                  busy;
    logic                                  done;
    logic [ADDR_W-1:0]                     address;
    logic [DATA_W-1:0]                     data;
    logic                                  wren;
    logic [DATA_W-1:0]                     q;

    modport master (
        input  start, key, key_len, q,
        output busy, done, address, data, wren
    );

    modport slave (
        output start, key, key_len, q,
        input  busy, done, address, data, wren
    );

endinterface

// File: rtl/rc4_key_sel.sv
// Key byte selector: a wrap-around byte index over the active key length.
// Byte 0 is the most significant byte of the key.
module rc4_key_sel
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear,
    input  logic                               advance,
    input  logic [MAX_KEY_BYTES*8-1:0]         key,
    input  logic [$clog2(MAX_KEY_BYTES+1)-1:0] len,
    output logic [DATA_W-1:0]                  kbyte
);

    localparam int KI_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

    logic [KI_W-1:0] r_kidx;

    // Compare-and-wrap instead of a modulo so no divider is inferred.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kidx <= '0;
        end else if (clear) begin
            r_kidx <= '0;
        end else if (advance) begin
            if (int'(r_kidx) + 1 >= int'(len)) begin
                r_kidx <= '0;
            end else begin
                r_kidx <= r_kidx + 1'b1;
            end
        end
    end

    always_comb begin
        kbyte = '0;
        for (int k = 0; k < MAX_KEY_BYTES; k++) begin
            if (int'(r_kidx) == k) begin
                kbyte = key[(MAX_KEY_BYTES-1-k)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: swaps S[i] and S[j] for i = 0..N-1 in an external
// single-port RAM that already holds the identity permutation.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int MAX_KEY_BYTES = 3,
    parameter int READ_LAT      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    rc4_ksa_engine_if.master bus
);

    localparam int KL_W  = $clog2(MAX_KEY_BYTES+1);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_I = '1;

    ksa_state_t                  r_state;
    logic [ADDR_W-1:0]           r_i;
    logic [ADDR_W-1:0]           r_j;
    logic [ADDR_W-1:0]           r_si;
    logic [MAX_KEY_BYTES*8-1:0]  r_key;
    logic [KL_W-1:0]             r_klen;
    logic [LAT_W-1:0]            r_lat;
    logic [ADDR_W-1:0]           r_address;
    logic [DATA_W-1:0]           r_data;
    logic                        r_wren;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_clear;
    logic                        w_advance;
    logic [DATA_W-1:0]           w_kbyte;
    logic [ADDR_W-1:0]           w_q;
    logic [ADDR_W-1:0]           w_jnext;

    assign w_clear   = (r_state == IDLE) && bus.start;
    assign w_advance = (r_state == WR_J) && (r_i != LAST_I);
    assign w_q       = bus.q[ADDR_W-1:0];
    assign w_jnext   = r_j + w_q + w_kbyte[ADDR_W-1:0];

    assign bus.address = r_address;
    assign bus.data    = r_data;
    assign bus.wren    = r_wren;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    rc4_key_sel #(
        .MAX_KEY_BYTES (MAX_KEY_BYTES)
    ) u_key_sel (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .advance (w_advance),
        .key     (r_key),
        .len     (r_klen),
        .kbyte   (w_kbyte)
    );

    // Outputs are loaded on the edge that enters a state, so each state's bus values
    // are visible for the whole cycle it occupies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_si      <= '0;
            r_key     <= '0;
            r_klen    <= '0;
            r_lat     <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_key     <= bus.key;
                        r_klen    <= KL_W'(eff_key_len(int'(bus.key_len), MAX_KEY_BYTES));
                        r_i       <= '0;
                        r_j       <= '0;
                        r_address <= '0;
                        r_wren    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= RD_I;
                    end
                end
                RD_I: begin
                    r_lat   <= LAT_W'(READ_LAT-1);
                    r_state <= WAIT_I;
                end
                WAIT_I: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - 1'b1;
                    end else begin
                        r_si      <= w_q;
                        r_j       <= w_jnext;
                        r_address <= w_jnext;
                        r_state   <= CALC_J;
                    end
                end
                CALC_J: begin
                    r_lat   <= LAT_W'(READ_LAT-1);
                    r_state <= WAIT_J;
                end
                WAIT_J: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - 1'b1;
                    end else begin
                        r_address <= r_i;
                        r_data    <= DATA_W'(w_q);
                        r_wren    <= 1'b1;
                        r_state   <= WR_I;
                    end
                end
                WR_I: begin
                    r_address <= r_j;
                    r_data    <= DATA_W'(r_si);
                    r_state   <= WR_J;
                end
                WR_J: begin
                    r_wren <= 1'b0;
                    if (r_i == LAST_I) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_i       <= r_i + 1'b1;
                        r_address <= r_i + 1'b1;
                        r_state   <= RD_I;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Scoreboard bench for rc4_ksa_engine: a golden KSA model queues every expected RAM
// write and a negedge monitor pops and compares each write the selected engine issues.
module tb_rc4_ksa_engine;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tbStart;
    logic [23:0] tbKey;
    logic [1:0]  tbKeyLen;
    logic        initMem;
    int          sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rc4_ksa_engine_if #(.ADDR_W(8), .MAX_KEY_BYTES(3)) bus0 ();
    rc4_ksa_engine_if #(.ADDR_W(8), .MAX_KEY_BYTES(3)) bus1 ();
    rc4_ksa_engine_if #(.ADDR_W(4), .MAX_KEY_BYTES(3)) bus2 ();

    assign bus0.start   = tbStart && (sel == 0);
    assign bus1.start   = tbStart && (sel == 1);
    assign bus2.start   = tbStart && (sel == 2);
    assign bus0.key     = tbKey;
    assign bus1.key     = tbKey;
    assign bus2.key     = tbKey;
    assign bus0.key_len = tbKeyLen;
    assign bus1.key_len = tbKeyLen;
    assign bus2.key_len = tbKeyLen;

    rc4_ksa_engine #(.ADDR_W(8), .MAX_KEY_BYTES(3), .READ_LAT(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    rc4_ksa_engine #(.ADDR_W(8), .MAX_KEY_BYTES(3), .READ_LAT(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    rc4_ksa_engine #(.ADDR_W(4), .MAX_KEY_BYTES(3), .READ_LAT(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    // RAM models: q follows the address by READ_LAT cycles; initMem reloads identity.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [16];
    logic [7:0] pipe1;

    always @(posedge clk) begin
        if (initMem) begin
            for (int a = 0; a < 256; a++) mem0[a] <= 8'(a);
        end else if (bus0.wren) begin
            mem0[bus0.address] <= bus0.data;
        end
        bus0.q <= mem0[bus0.address];
    end

    always @(posedge clk) begin
        if (initMem) begin
            for (int a = 0; a < 256; a++) mem1[a] <= 8'(a);
        end else if (bus1.wren) begin
            mem1[bus1.address] <= bus1.data;
        end
        pipe1  <= mem1[bus1.address];
        bus1.q <= pipe1;
    end

    always @(posedge clk) begin
        if (initMem) begin
            for (int a = 0; a < 16; a++) mem2[a] <= 8'(a);
        end else if (bus2.wren) begin
            mem2[bus2.address] <= bus2.data;
        end
        bus2.q <= mem2[bus2.address];
    end

    // The engine under test is picked by sel; the monitor only looks at that one.
    logic       monWren, monBusy, monDone;
    logic [7:0] monAddr, monData;

    always_comb begin
        monWren = bus0.wren;
        monBusy = bus0.busy;
        monDone = bus0.done;
        monAddr = bus0.address;
        monData = bus0.data;
        if (sel == 1) begin
            monWren = bus1.wren;
            monBusy = bus1.busy;
            monDone = bus1.done;
            monAddr = bus1.address;
            monData = bus1.data;
        end else if (sel == 2) begin
            monWren = bus2.wren;
            monBusy = bus2.busy;
            monDone = bus2.done;
            monAddr = 8'(bus2.address);
            monData = bus2.data;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    logic [15:0] expQ [$];
    logic [15:0] wlog [$];
    logic [15:0] expE;

    always @(negedge clk) begin
        if (reset_n && monWren) begin
            wlog.push_back({monAddr, monData});
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual=0x%0h required=none", {monAddr, monData});
            end else begin
                expE = expQ.pop_front();
                checkOutput("ram_write", int'({monAddr, monData}), int'(expE));
            end
        end
    end

    // Golden KSA: queues {addr,data} for the S[i] write then the S[j] write.
    int ms [256];

    task automatic modelKsa(input int aw, input logic [23:0] k, input int klen);
        int n;
        int j;
        int kl;
        int kidx;
        int kb;
        int t;
        n    = 1 << aw;
        j    = 0;
        kidx = 0;
        kl   = (klen == 0 || klen > 3) ? 3 : klen;
        for (int a = 0; a < n; a++) ms[a] = a;
        for (int i = 0; i < n; i++) begin
            kb = int'((k >> (8 * (2 - kidx))) & 24'hFF);
            j  = (j + ms[i] + kb) % n;
            expQ.push_back({8'(i), 8'(ms[j])});
            expQ.push_back({8'(j), 8'(ms[i])});
            t     = ms[i];
            ms[i] = ms[j];
            ms[j] = t;
            kidx  = (kidx + 1) % kl;
        end
    endtask

    function automatic int rdMem(input int s, input int a);
        if (s == 1) return int'(mem1[a]);
        if (s == 2) return int'(mem2[a]);
        return int'(mem0[a]);
    endfunction

    // pulseAt: cycle to pulse start while busy; resetAt: cycle to drop reset_n (-1 = never).
    task automatic applyStimulus(input int s, input logic [23:0] k, input logic [1:0] kl,
                                 input int expLat, input int pulseAt, input int resetAt);
        int n;
        int doneCount;
        int busyDrop;
        int bad;
        int aw;
        aw       = (s == 2) ? 4 : 8;
        busyDrop = 0;
        sel      = s;
        initMem  = 1'b1;
        @(negedge clk);
        initMem  = 1'b0;
        expQ.delete();
        wlog.delete();
        modelKsa(aw, k, int'(kl));
        tbKey    = k;
        tbKeyLen = kl;
        tbStart  = 1'b1;
        @(negedge clk);
        tbStart  = 1'b0;
        tbKey    = ~k;
        tbKeyLen = 2'd1;
        n = 1;
        while (!monDone && n < expLat + 40) begin
            if (!monBusy) busyDrop = 1;
            tbStart = (n == pulseAt);
            if (n == resetAt) begin
                checkOutput("wren_before_reset", int'(monWren), 1);
                #1 reset_n = 1'b0;
                #1;
                checkOutput("reset_address", int'(monAddr), 0);
                checkOutput("reset_data", int'(monData), 0);
                checkOutput("reset_wren", int'(monWren), 0);
                checkOutput("reset_busy", int'(monBusy), 0);
                checkOutput("reset_done", int'(monDone), 0);
                @(negedge clk);
                reset_n = 1'b1;
                tbStart = 1'b0;
                expQ.delete();
                @(negedge clk);
                checkOutput("idle_after_reset", int'(monBusy), 0);
                return;
            end
            @(negedge clk);
            n++;
        end
        tbStart = 1'b0;
        checkOutput("done_latency", n, expLat);
        checkOutput("busy_throughout", busyDrop, 0);
        checkOutput("busy_low_at_done", int'(monBusy), 0);
        doneCount = int'(monDone);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("done_single_pulse", int'(monDone), 0);
            doneCount += int'(monDone);
        end
        checkOutput("done_count", doneCount, 1);
        checkOutput("writes_outstanding", expQ.size(), 0);
        bad = 0;
        for (int a = 0; a < (1 << aw); a++) begin
            if (rdMem(s, a) != ms[a]) bad++;
        end
        checkOutput("final_array_mismatches", bad, 0);
    endtask

    initial begin
        logic [15:0] seen;
        int          upper;
        tbStart  = 1'b0;
        tbKey    = '0;
        tbKeyLen = '0;
        initMem  = 1'b0;
        sel      = 0;
        reset_n  = 1'b0;
        #2;
        checkOutput("por_address", int'(monAddr), 0);
        checkOutput("por_data", int'(monData), 0);
        checkOutput("por_wren", int'(monWren), 0);
        checkOutput("por_busy", int'(monBusy), 0);
        checkOutput("por_done", int'(monDone), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] key 000249 len 3");
        applyStimulus(0, 24'h000249, 2'd3, 1537, -1, -1);
        checkOutput("k3_it0_wr_i", int'(wlog[0]), 16'h0000);
        checkOutput("k3_it0_wr_j", int'(wlog[1]), 16'h0000);
        checkOutput("k3_it1_wr_i", int'(wlog[2]), 16'h0103);
        checkOutput("k3_it1_wr_j", int'(wlog[3]), 16'h0301);
        checkOutput("k3_it2_wr_i", int'(wlog[4]), 16'h024E);
        checkOutput("k3_it2_wr_j", int'(wlog[5]), 16'h4E02);

        $display("[TB] key byte0 01 len 1");
        applyStimulus(0, 24'h01A5C3, 2'd1, 1537, -1, -1);
        checkOutput("k1_it0_wr_i", int'(wlog[0]), 16'h0001);
        checkOutput("k1_it0_wr_j", int'(wlog[1]), 16'h0100);
        checkOutput("k1_it1_wr_i", int'(wlog[2]), 16'h0102);
        checkOutput("k1_it1_wr_j", int'(wlog[3]), 16'h0200);
        checkOutput("k1_it2_wr_i", int'(wlog[4]), 16'h0203);
        checkOutput("k1_it2_wr_j", int'(wlog[5]), 16'h0300);

        $display("[TB] key_len 0 clamps to full length");
        applyStimulus(0, 24'h000249, 2'd0, 1537, -1, -1);
        checkOutput("k0_it2_wr_i", int'(wlog[4]), 16'h024E);

        $display("[TB] start pulse at iteration 10 while busy");
        applyStimulus(0, 24'h000249, 2'd3, 1537, 61, -1);

        $display("[TB] reset during WR_I of iteration 7, then rerun");
        applyStimulus(0, 24'h5A3C96, 2'd3, 1537, -1, 47);
        applyStimulus(0, 24'h5A3C96, 2'd3, 1537, -1, -1);

        $display("[TB] READ_LAT 2");
        applyStimulus(1, 24'h000249, 2'd3, 2049, -1, -1);

        $display("[TB] ADDR_W 4 key 0F0102");
        applyStimulus(2, 24'h0F0102, 2'd3, 97, -1, -1);
        seen  = '0;
        upper = 0;
        for (int a = 0; a < 16; a++) begin
            seen[mem2[a][3:0]] = 1'b1;
            if (mem2[a][7:4] != 4'h0) upper++;
        end
        checkOutput("aw4_permutation", int'(seen), 16'hFFFF);
        checkOutput("aw4_upper_bits_zero", upper, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
